// File: rtl/fmul_arbiter.sv
// ---------------------------------------------------------------------------
// fmul_arbiter
//
// Shares a single pipelined fmul unit (fixed latency NSTAGE, no stall) among
// NREQ requesters. A round-robin arbiter picks at most one requester per
// cycle, registers its operands towards the fmul, and carries the requester
// ID alongside the operation in a tag pipeline. When the result comes out
// of the fmul it is registered together with the tag and presented on one
// shared response bus.
//
// Latency: handshake in cycle t -> rsp_valid high in cycle t+NSTAGE+2.
//
// Ports:
//   clk            clock, all state on the rising edge
//   rstn           synchronous active-low reset
//   req_valid      [NREQ]     requester i presents operands
//   req_ready      [NREQ]     grant to requester i (combinational on req_valid)
//   req_x1/req_x2  [32*NREQ]  operands, slice [32i+31:32i] for requester i
//   fmul_x1/x2     [32]       registered operands driven to the fmul
//   fmul_y         [32]       fmul result
//   fmul_ovf       [1]        fmul overflow flag
//   rsp_valid      [1]        one-cycle pulse per completed operation
//   rsp_id         [IDW]      requester that issued the operation
//   rsp_y/rsp_ovf  [32]/[1]   registered result and overflow flag
//
// Optional feature (macro FMUL_ARB_PERF_EN):
//   perf_issue     [32]       count of granted cycles
//   perf_conflict  [32]       count of cycles with two or more requests
// ---------------------------------------------------------------------------
module fmul_arbiter #(
  parameter int NREQ   = 4,
  parameter int NSTAGE = 2,
  parameter int IDW    = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [32*NREQ-1:0]   req_x1,
  input  logic [32*NREQ-1:0]   req_x2,
  output logic [31:0]          fmul_x1,
  output logic [31:0]          fmul_x2,
  input  logic [31:0]          fmul_y,
  input  logic                 fmul_ovf,
  output logic                 rsp_valid,
  output logic [IDW-1:0]       rsp_id,
  output logic [31:0]          rsp_y,
  output logic                 rsp_ovf
`ifdef FMUL_ARB_PERF_EN
  ,
  output logic [31:0]          perf_issue,
  output logic [31:0]          perf_conflict
`endif
);

  // Round-robin pointer: index of the most recently granted requester.
  logic [IDW-1:0] ptr;

  logic [IDW-1:0] gnt_idx;
  logic [IDW-1:0] scan_idx;
  logic           found;
  logic           grant;
  logic [31:0]    sel_x1;
  logic [31:0]    sel_x2;

  // Tag pipeline. Stage 0 travels with the operand register (valid in the
  // cycle the operands are applied to the fmul); stages 1..NSTAGE follow the
  // fmul latency, so stage NSTAGE lines up with fmul_y.
  logic           tag_v  [0:NSTAGE];
  logic [IDW-1:0] tag_id [0:NSTAGE];

  // Scan requesters starting just after the pointer, wrapping at NREQ; the
  // first valid one wins.
  always_comb begin
    found    = 1'b0;
    gnt_idx  = '0;
    scan_idx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      scan_idx = IDW'((int'(ptr) + k) % NREQ);
      if (!found && req_valid[scan_idx]) begin
        found   = 1'b1;
        gnt_idx = scan_idx;
      end
    end
  end

  // Nothing is granted while reset is asserted.
  assign grant = found & rstn;

  // One-hot ready towards the requesters, plus the operand mux for the winner.
  always_comb begin
    req_ready = '0;
    sel_x1    = '0;
    sel_x2    = '0;
    if (grant) begin
      req_ready[gnt_idx] = 1'b1;
    end
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == IDW'(i)) begin
        sel_x1 = req_x1[32*i +: 32];
        sel_x2 = req_x2[32*i +: 32];
      end
    end
  end

  // Pointer starts at NREQ-1 so requester 0 has first priority after reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ptr <= IDW'(NREQ - 1);
    end else if (grant) begin
      ptr <= gnt_idx;
    end
  end

  // Issue stage and tag shift. Operands hold when nothing is granted so the
  // fmul inputs do not toggle needlessly; only the tag valid bit matters.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      fmul_x1 <= '0;
      fmul_x2 <= '0;
      for (int k = 0; k <= NSTAGE; k++) begin
        tag_v[k]  <= 1'b0;
        tag_id[k] <= '0;
      end
    end else begin
      if (grant) begin
        fmul_x1 <= sel_x1;
        fmul_x2 <= sel_x2;
      end
      tag_v[0]  <= grant;
      tag_id[0] <= gnt_idx;
      for (int k = 1; k <= NSTAGE; k++) begin
        tag_v[k]  <= tag_v[k-1];
        tag_id[k] <= tag_id[k-1];
      end
    end
  end

  // Response register: captures the fmul output only when the aligned tag is
  // valid, otherwise the bus keeps its last values.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_y     <= '0;
      rsp_ovf   <= 1'b0;
    end else begin
      rsp_valid <= tag_v[NSTAGE];
      if (tag_v[NSTAGE]) begin
        rsp_id  <= tag_id[NSTAGE];
        rsp_y   <= fmul_y;
        rsp_ovf <= fmul_ovf;
      end
    end
  end

`ifdef FMUL_ARB_PERF_EN
  // Free-running performance counters; both wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      perf_issue    <= '0;
      perf_conflict <= '0;
    end else begin
      if (grant) begin
        perf_issue <= perf_issue + 32'd1;
      end
      if ($countones(req_valid) > 1) begin
        perf_conflict <= perf_conflict + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fmul_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fmul_arbiter
//
// Self-checking bench for fmul_arbiter (NREQ=4, NSTAGE=2). A behavioural
// fmul (simple truncating float multiply with overflow to inf) sits on the
// fmul_* ports. A table of {req_valid, expected req_ready, operands} is
// applied one row per cycle; each expected grant pushes the expected
// response onto a scoreboard queue, which a monitor pops when rsp_valid
// pulses and checks id, data, overflow and arrival cycle.
// ---------------------------------------------------------------------------
module tb_fmul_arbiter;

  localparam int NREQ   = 4;
  localparam int NSTAGE = 2;
  localparam int IDW    = 2;

  logic                clk;
  logic                rstn;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [32*NREQ-1:0]  req_x1;
  logic [32*NREQ-1:0]  req_x2;
  logic [31:0]         fmul_x1;
  logic [31:0]         fmul_x2;
  logic [31:0]         fmul_y;
  logic                fmul_ovf;
  logic                rsp_valid;
  logic [IDW-1:0]      rsp_id;
  logic [31:0]         rsp_y;
  logic                rsp_ovf;
`ifdef FMUL_ARB_PERF_EN
  logic [31:0]         perf_issue;
  logic [31:0]         perf_conflict;
`endif

  fmul_arbiter #(.NREQ(NREQ), .NSTAGE(NSTAGE), .IDW(IDW)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_x1        (req_x1),
    .req_x2        (req_x2),
    .fmul_x1       (fmul_x1),
    .fmul_x2       (fmul_x2),
    .fmul_y        (fmul_y),
    .fmul_ovf      (fmul_ovf),
    .rsp_valid     (rsp_valid),
    .rsp_id        (rsp_id),
    .rsp_y         (rsp_y),
    .rsp_ovf       (rsp_ovf)
`ifdef FMUL_ARB_PERF_EN
    ,
    .perf_issue    (perf_issue),
    .perf_conflict (perf_conflict)
`endif
  );

  // Clock generation.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference float multiply returning {ovf, y}: truncating, flush-to-zero.
  function automatic logic [32:0] fmulRef(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    logic [23:0] ma;
    logic [23:0] mb;
    logic [47:0] p;
    logic [22:0] m;
    int          e;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {1'b0, s, 31'd0};
    ma = {1'b1, a[22:0]};
    mb = {1'b1, b[22:0]};
    p  = 48'(ma) * 48'(mb);
    e  = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin
      m = p[46:24];
      e = e + 1;
    end else begin
      m = p[45:23];
    end
    if (e >= 255) return {1'b1, s, 8'hFF, 23'd0};
    if (e <= 0) return {1'b0, s, 31'd0};
    return {1'b0, s, 8'(e), m};
  endfunction

  // Behavioural fmul: operands in cycle c give a result in cycle c+NSTAGE.
  logic [32:0] fpipe [NSTAGE];
  initial begin
    for (int k = 0; k < NSTAGE; k++) fpipe[k] = '0;
  end
  always @(posedge clk) begin
    fpipe[0] <= fmulRef(fmul_x1, fmul_x2);
    for (int k = 1; k < NSTAGE; k++) fpipe[k] <= fpipe[k-1];
  end
  assign {fmul_ovf, fmul_y} = fpipe[NSTAGE-1];

  // Cycle counter, stable when sampled on the falling edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int          id;
    logic [31:0] y;
    logic        ovf;
    int          due;
  } rsp_t;
  rsp_t sb[$];

  typedef struct {
    logic [NREQ-1:0] valid;
    logic [NREQ-1:0] ready;
    int              sel;
    logic [31:0]     x1;
    logic [31:0]     x2;
  } vec_t;
  vec_t vecs[$];

  logic [31:0]     cx1 [NREQ];
  logic [31:0]     cx2 [NREQ];
  logic [NREQ-1:0] pend = '0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] randFloat();
    logic [7:0] e;
    e = 8'(100 + $urandom_range(0, 54));
    return {1'($urandom_range(0, 1)), e, 23'($urandom)};
  endfunction

  function automatic void addVec(input logic [NREQ-1:0] v, input logic [NREQ-1:0] r,
                                 input int sel, input logic [31:0] x1, input logic [31:0] x2);
    vec_t t;
    t.valid = v;
    t.ready = r;
    t.sel   = sel;
    t.x1    = x1;
    t.x2    = x2;
    vecs.push_back(t);
  endfunction

  // Drive one cycle of requests; operands only change for requesters that
  // are not waiting on a grant. The expected grant queues its response.
  task automatic applyStimulus(input logic [NREQ-1:0] v, input logic [NREQ-1:0] r,
                               input int sel, input logic [31:0] x1, input logic [31:0] x2);
    rsp_t e;
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (!pend[i]) begin
        cx1[i] = randFloat();
        cx2[i] = randFloat();
      end
    end
    if (sel >= 0) begin
      cx1[sel] = x1;
      cx2[sel] = x2;
    end
    for (int i = 0; i < NREQ; i++) begin
      req_x1[32*i +: 32] = cx1[i];
      req_x2[32*i +: 32] = cx2[i];
    end
    rstn      = 1'b1;
    req_valid = v;
    @(negedge clk);
    checkOutput("req_ready", 32'(req_ready), 32'(r));
    for (int i = 0; i < NREQ; i++) begin
      if (r[i]) begin
        e.id  = i;
        {e.ovf, e.y} = fmulRef(cx1[i], cx2[i]);
        e.due = cyc + NSTAGE + 2;
        sb.push_back(e);
      end
    end
    pend = v & ~r;
  endtask

  // Hold reset for n cycles with every requester asserting; ready must stay
  // low, and after two reset edges every register is back at zero.
  task automatic doReset(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      rstn      = 1'b0;
      req_valid = '1;
      @(negedge clk);
      checkOutput("ready_in_reset", 32'(req_ready), 32'd0);
      if (i >= 1) begin
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_rsp_id", 32'(rsp_id), 32'd0);
        checkOutput("rst_rsp_y", rsp_y, 32'd0);
        checkOutput("rst_rsp_ovf", 32'(rsp_ovf), 32'd0);
        checkOutput("rst_fmul_x1", fmul_x1, 32'd0);
        checkOutput("rst_fmul_x2", fmul_x2, 32'd0);
`ifdef FMUL_ARB_PERF_EN
        checkOutput("rst_perf_issue", perf_issue, 32'd0);
        checkOutput("rst_perf_conflict", perf_conflict, 32'd0);
`endif
      end
    end
    pend = '0;
  endtask

  // Response monitor: pop on every rsp_valid pulse, flag overdue entries,
  // and drop all in-flight expectations when reset is sampled.
  always @(negedge clk) begin
    rsp_t e;
    if (rsp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("rsp_unexpected", 32'(rsp_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("rsp_id", 32'(rsp_id), 32'(e.id));
        checkOutput("rsp_y", rsp_y, e.y);
        checkOutput("rsp_ovf", 32'(rsp_ovf), 32'(e.ovf));
        checkOutput("rsp_cycle", 32'(cyc), 32'(e.due));
      end
    end else if (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      checkOutput("rsp_missing", 32'(rsp_valid), 32'd1);
    end
    if (rstn === 1'b0) sb.delete();
  end

  initial begin
    rstn      = 1'b0;
    req_valid = '0;
    req_x1    = '0;
    req_x2    = '0;
    for (int i = 0; i < NREQ; i++) begin
      cx1[i] = '0;
      cx2[i] = '0;
    end

    // Round-robin with everyone asserting from reset release.
    addVec(4'b1111, 4'b0001, -1, 32'h0, 32'h0);
    addVec(4'b1111, 4'b0010, -1, 32'h0, 32'h0);
    addVec(4'b1111, 4'b0100, -1, 32'h0, 32'h0);
    addVec(4'b1111, 4'b1000, -1, 32'h0, 32'h0);
    addVec(4'b1111, 4'b0001, -1, 32'h0, 32'h0);
    addVec(4'b1111, 4'b0010, -1, 32'h0, 32'h0);
    addVec(4'b0000, 4'b0000, -1, 32'h0, 32'h0);
    // Single op: 3.0 * 2.0 from requester 2.
    addVec(4'b0100, 4'b0100,  2, 32'h40400000, 32'h40000000);
    addVec(4'b0000, 4'b0000, -1, 32'h0, 32'h0);
    // Overflow passthrough from requester 1.
    addVec(4'b0010, 4'b0010,  1, 32'h7F000000, 32'h7F000000);
    addVec(4'b0000, 4'b0000, -1, 32'h0, 32'h0);
    // Sparse 0/3 alternation, then 3 withdraws before being granted.
    addVec(4'b0001, 4'b0001, -1, 32'h0, 32'h0);
    addVec(4'b1001, 4'b1000, -1, 32'h0, 32'h0);
    addVec(4'b1001, 4'b0001, -1, 32'h0, 32'h0);
    addVec(4'b1001, 4'b1000, -1, 32'h0, 32'h0);
    addVec(4'b1001, 4'b0001, -1, 32'h0, 32'h0);
    addVec(4'b0001, 4'b0001, -1, 32'h0, 32'h0);
    addVec(4'b0000, 4'b0000, -1, 32'h0, 32'h0);
    // Back-to-back grants to a lone requester.
    addVec(4'b0100, 4'b0100, -1, 32'h0, 32'h0);
    addVec(4'b0100, 4'b0100, -1, 32'h0, 32'h0);
    addVec(4'b0100, 4'b0100, -1, 32'h0, 32'h0);
    // Mixed patterns across the wrap point.
    addVec(4'b0011, 4'b0001, -1, 32'h0, 32'h0);
    addVec(4'b0011, 4'b0010, -1, 32'h0, 32'h0);
    addVec(4'b1010, 4'b1000, -1, 32'h0, 32'h0);
    addVec(4'b0110, 4'b0010, -1, 32'h0, 32'h0);
    addVec(4'b0000, 4'b0000, -1, 32'h0, 32'h0);

    doReset(3);
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].valid, vecs[i].ready, vecs[i].sel, vecs[i].x1, vecs[i].x2);
    end
    repeat (NSTAGE + 3) applyStimulus(4'b0000, 4'b0000, -1, 32'h0, 32'h0);

    // Reset mid-flight: two ops issued, reset drops them, requester 0 wins next.
    applyStimulus(4'b0001, 4'b0001, -1, 32'h0, 32'h0);
    applyStimulus(4'b0010, 4'b0010, -1, 32'h0, 32'h0);
    doReset(1);
    applyStimulus(4'b1111, 4'b0001, -1, 32'h0, 32'h0);
    repeat (NSTAGE + 3) applyStimulus(4'b0000, 4'b0000, -1, 32'h0, 32'h0);

`ifdef FMUL_ARB_PERF_EN
    // Ten conflicting cycles with three requesters asserting.
    doReset(2);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(4'b0111, 4'(4'b0001 << (i % 3)), -1, 32'h0, 32'h0);
    end
    applyStimulus(4'b0000, 4'b0000, -1, 32'h0, 32'h0);
    checkOutput("perf_issue", perf_issue, 32'd10);
    checkOutput("perf_conflict", perf_conflict, 32'd10);
    repeat (NSTAGE + 3) applyStimulus(4'b0000, 4'b0000, -1, 32'h0, 32'h0);
`endif

    checkOutput("sb_drained", 32'(sb.size()), 32'd0);
    doReset(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
